// File: rtl/hidden_layer_scheduler.sv
// Purpose: pops active-pixel indices and issues one weight read per hidden neuron, steering read data into accumulators.
// Latency: NUM_NEURONS+1 cycles per valid index; accEnable trails weightRead by MEM_LATENCY cycles; done MEM_LATENCY cycles after the queue drains.
// Backpressure: pops only when queueEmpty=0, never on consecutive cycles; layerDone holds until layerAck.
module hidden_layer_scheduler #(
    parameter int INPUT_COUNT = 784,
    parameter int NUM_NEURONS = 16,
    parameter int INDEX_W     = 10,
    parameter int ADDR_W      = 14,
    parameter int MEM_LATENCY = 2,
    localparam int NEURON_W   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int DRAIN_W    = $clog2(MEM_LATENCY + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inputsReady,
    input  logic                queueEmpty,
    input  logic [INDEX_W-1:0]  indexIn,
    output logic                dequeue,
    output logic                weightRead,
    output logic [ADDR_W-1:0]   weightAddr,
    output logic                accClear,
    output logic                accEnable,
    output logic [NEURON_W-1:0] accNeuron,
    output logic                layerDone,
    input  logic                layerAck,
    output logic                indexError
);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, DRAIN, DONE} state_t;

    state_t               state;
    state_t               nextState;
    logic [INDEX_W-1:0]   curIndex;
    logic [NEURON_W-1:0]  neuron;
    logic [DRAIN_W-1:0]   drainCnt;
    // After popping an out-of-range index we sit out one cycle so the queue
    // is never popped on two consecutive cycles.
    logic                 popGap;
    logic                 indexBad;
    logic                 fetchValid;
    logic                 lastNeuron;
    logic [MEM_LATENCY-1:0] rdPipe;
    logic [NEURON_W-1:0]  nrPipe [MEM_LATENCY];

    assign indexBad   = ({{(32-INDEX_W){1'b0}}, indexIn} >= 32'(INPUT_COUNT));
    assign fetchValid = (state == FETCH) && !popGap && !queueEmpty;
    assign lastNeuron = (neuron == NEURON_W'(NUM_NEURONS - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decision
    always_comb begin
        nextState = state;
        case (state)
            IDLE:  if (inputsReady) nextState = FETCH;
            FETCH: begin
                if (popGap) begin
                    nextState = FETCH;
                end else if (queueEmpty) begin
                    nextState = DRAIN;
                end else if (!indexBad) begin
                    nextState = ISSUE;
                end
            end
            ISSUE: if (lastNeuron) nextState = FETCH;
            DRAIN: if (drainCnt == DRAIN_W'(MEM_LATENCY - 1)) nextState = DONE;
            DONE:  if (layerAck) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs decoded from state; accClear is masked while reset is held
    always_comb begin
        dequeue    = fetchValid;
        weightRead = (state == ISSUE);
        weightAddr = '0;
        if (state == ISSUE) begin
            weightAddr = ADDR_W'(curIndex) * ADDR_W'(NUM_NEURONS) + ADDR_W'(neuron);
        end
        accClear   = (state == IDLE) && inputsReady && !reset;
        layerDone  = (state == DONE);
        accEnable  = rdPipe[MEM_LATENCY-1];
        accNeuron  = nrPipe[MEM_LATENCY-1];
    end

    // Index latch, neuron/drain counters, pop spacing and sticky error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curIndex   <= '0;
            neuron     <= '0;
            drainCnt   <= '0;
            popGap     <= 1'b0;
            indexError <= 1'b0;
        end else begin
            if (fetchValid) begin
                curIndex <= indexIn;
            end
            if (state == ISSUE) begin
                neuron <= lastNeuron ? '0 : neuron + 1'b1;
            end else begin
                neuron <= '0;
            end
            drainCnt   <= (state == DRAIN) ? drainCnt + 1'b1 : '0;
            popGap     <= fetchValid && indexBad;
            indexError <= indexError | (fetchValid && indexBad);
        end
    end

    // Delay read strobe and neuron number to line up with the memory data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPipe <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                nrPipe[i] <= '0;
            end
        end else begin
            rdPipe[0] <= (state == ISSUE);
            nrPipe[0] <= neuron;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                rdPipe[i] <= rdPipe[i-1];
                nrPipe[i] <= nrPipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_hidden_layer_scheduler.sv
// Purpose: drives images of pixel indices through the scheduler and checks its schedule against a cycle-level model.
// Latency: not applicable (testbench).
// Backpressure: the bench models the index queue and pops it on each observed dequeue.
module tb_hidden_layer_scheduler;
    localparam int IC = 784;
    localparam int NN = 16;
    localparam int IW = 10;
    localparam int AW = 14;
    localparam int ML = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          inputsReady;
    logic          queueEmpty;
    logic [IW-1:0] indexIn;
    logic          dequeue;
    logic          weightRead;
    logic [AW-1:0] weightAddr;
    logic          accClear;
    logic          accEnable;
    logic [3:0]    accNeuron;
    logic          layerDone;
    logic          layerAck;
    logic          indexError;

    always #5 clk = ~clk;

    hidden_layer_scheduler dut (
        .clk(clk), .reset(reset), .inputsReady(inputsReady), .queueEmpty(queueEmpty),
        .indexIn(indexIn), .dequeue(dequeue), .weightRead(weightRead), .weightAddr(weightAddr),
        .accClear(accClear), .accEnable(accEnable), .accNeuron(accNeuron),
        .layerDone(layerDone), .layerAck(layerAck), .indexError(indexError)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int q[$];
    int obsDeq[$], obsRd[$], obsAddr[$], obsAcc[$], obsNr[$], obsClr[$];
    int expDeq[$], expRd[$], expAddr[$], expAcc[$], expNr[$];
    int expDone;
    int doneRise;
    int viol;
    logic prevDeq, prevDone, sawDeq, lastDone, lastClr, expErr;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cmpList(input string tag, input int o[$], input int e[$]);
        int at;
        int n;
        at = -1;
        n = (o.size() > e.size()) ? o.size() : e.size();
        for (int i = 0; i < n; i++) begin
            if (at < 0 && (i >= o.size() || i >= e.size() || o[i] != e[i])) at = i;
        end
        total++;
        assert (at < 0) else begin
            bad++;
            $error("FAIL %s first diff at %0d observed=%0d expected=%0d sizes %0d/%0d", tag, at,
                   (at < o.size()) ? o[at] : -1, (at < e.size()) ? e[at] : -1, o.size(), e.size());
        end
    endtask

    task automatic driveQueue();
        queueEmpty = (q.size() == 0);
        indexIn    = (q.size() != 0) ? IW'(q[0]) : '0;
    endtask

    task automatic clearObs();
        obsDeq.delete(); obsRd.delete(); obsAddr.delete();
        obsAcc.delete(); obsNr.delete(); obsClr.delete();
        viol = 0;
        doneRise = -1;
    endtask

    // One clock cycle: sample at negedge, then pop the queue model after the edge
    task automatic tick();
        @(negedge clk);
        sawDeq = dequeue;
        if (dequeue) begin
            obsDeq.push_back(cyc);
            if (queueEmpty || prevDeq) viol++;
        end
        if (weightRead) begin
            obsRd.push_back(cyc);
            obsAddr.push_back(int'(weightAddr));
        end
        if (accEnable) begin
            obsAcc.push_back(cyc);
            obsNr.push_back(int'(accNeuron));
            if (accClear) viol++;
        end
        if (accClear) obsClr.push_back(cyc);
        if (layerDone && !prevDone && doneRise < 0) doneRise = cyc;
        prevDeq  = dequeue;
        prevDone = layerDone;
        lastDone = layerDone;
        lastClr  = accClear;
        @(posedge clk);
        cyc++;
        #1;
        if (sawDeq && q.size() != 0) void'(q.pop_front());
        driveQueue();
    endtask

    // Schedule from the rules: one pop per index, 16 reads per legal index,
    // a lost cycle after an illegal one, one empty fetch, then ML drain cycles.
    task automatic buildExpected(input int idxs[$], input int t0);
        int c;
        expDeq.delete(); expRd.delete(); expAddr.delete(); expAcc.delete(); expNr.delete();
        c = t0 + 1;
        foreach (idxs[k]) begin
            expDeq.push_back(c);
            if (idxs[k] < IC) begin
                for (int n = 0; n < NN; n++) begin
                    expRd.push_back(c + 1 + n);
                    expAddr.push_back(idxs[k] * NN + n);
                    expAcc.push_back(c + 1 + n + ML);
                    expNr.push_back(n);
                end
                c += NN + 1;
            end else begin
                expErr = 1'b1;
                c += 2;
            end
        end
        expDone = c + 1 + ML;
    endtask

    task automatic runImage(input int idxs[$], input int hold, input bit keepReady, input string tag);
        int t0;
        int guard;
        int nLow;
        int nEv;
        int sz;
        int clrExp[$];
        clearObs();
        q = idxs;
        driveQueue();
        inputsReady = 1'b1;
        t0 = cyc;
        tick();
        if (!keepReady) inputsReady = 1'b0;
        guard = 0;
        while (doneRise < 0 && guard < 2000) begin
            tick();
            guard++;
        end
        buildExpected(idxs, t0);
        clrExp.push_back(t0);
        check({tag, " doneRise"}, doneRise, expDone);
        cmpList({tag, " accClear"}, obsClr, clrExp);
        cmpList({tag, " dequeue"}, obsDeq, expDeq);
        cmpList({tag, " readCycle"}, obsRd, expRd);
        cmpList({tag, " weightAddr"}, obsAddr, expAddr);
        cmpList({tag, " accCycle"}, obsAcc, expAcc);
        cmpList({tag, " accNeuron"}, obsNr, expNr);
        check({tag, " indexError"}, int'(indexError), int'(expErr));
        check({tag, " protocol"}, viol, 0);
        nLow = 0;
        nEv  = 0;
        for (int i = 0; i < hold; i++) begin
            sz = obsDeq.size() + obsClr.size() + obsRd.size();
            tick();
            if (!lastDone) nLow++;
            if (obsDeq.size() + obsClr.size() + obsRd.size() != sz) nEv++;
        end
        check({tag, " doneHeld"}, nLow, 0);
        check({tag, " quietInDone"}, nEv, 0);
        layerAck = 1'b1;
        tick();
        layerAck = 1'b0;
        check({tag, " doneAtAck"}, int'(lastDone), 1);
        if (!keepReady) begin
            tick();
            check({tag, " doneDrop"}, int'(lastDone), 0);
        end
    endtask

    initial begin
        int lst[$];
        int guard;
        reset = 1'b1; inputsReady = 1'b0; layerAck = 1'b0;
        queueEmpty = 1'b1; indexIn = '0;
        prevDeq = 1'b0; prevDone = 1'b0; expErr = 1'b0;
        clearObs();
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", int'({dequeue, weightRead, accClear, accEnable, layerDone, indexError, weightAddr, accNeuron}), 0);
        reset = 1'b0;

        lst.delete(); lst.push_back(5);
        runImage(lst, 0, 1'b0, "single");
        lst.delete();
        runImage(lst, 0, 1'b0, "empty");
        lst.delete(); lst.push_back(0); lst.push_back(783);
        runImage(lst, 0, 1'b0, "multi");
        lst.delete(); lst.push_back(12);
        runImage(lst, 10, 1'b1, "handshake");
        lst.delete(); lst.push_back(40);
        runImage(lst, 0, 1'b0, "nextImage");
        lst.delete(); lst.push_back(800); lst.push_back(3);
        runImage(lst, 1, 1'b0, "badIndex");

        for (int img = 0; img < 6; img++) begin
            int n;
            lst.delete();
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 99) < 15) lst.push_back($urandom_range(IC, 1023));
                else lst.push_back($urandom_range(0, IC - 1));
            end
            runImage(lst, $urandom_range(0, 3), 1'b0, $sformatf("random%0d", img));
        end

        // Reset in the middle of issuing reads
        clearObs();
        q.delete(); q.push_back(7); q.push_back(9);
        driveQueue();
        inputsReady = 1'b1;
        tick();
        inputsReady = 1'b0;
        guard = 0;
        while (obsRd.size() < 3 && guard < 100) begin
            tick();
            guard++;
        end
        check("reached issue", (obsRd.size() >= 3) ? 1 : 0, 1);
        check("accEnable before reset", int'(accEnable), 1);
        reset = 1'b1;
        #1;
        check("midReset outputs", int'({dequeue, weightRead, accClear, accEnable, layerDone, indexError, weightAddr, accNeuron}), 0);
        clearObs();
        inputsReady = 1'b1;
        repeat (3) tick();
        check("activity in reset", obsDeq.size() + obsAcc.size() + obsClr.size() + obsRd.size(), 0);
        expErr = 1'b0;
        q.delete();
        driveQueue();
        reset = 1'b0;
        lst.delete();
        runImage(lst, 0, 1'b0, "postReset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
